// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter: port ids, the
// response-order FIFO entry and the round-robin successor function.
package sdram_arb_pkg;

    localparam int PORT_ID_MAX_W = 3;   // up to 8 requesters
    localparam int LEN_MAX_W     = 16;  // widest supported burst-length field

    typedef logic [PORT_ID_MAX_W-1:0] port_id_t;

    typedef struct packed {
        port_id_t               port;
        logic [LEN_MAX_W-1:0]   count;  // responses still expected after the next one
    } resp_entry_t;

    function automatic int port_id_w(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    function automatic port_id_t rr_next(input port_id_t cur, input port_id_t last);
        return (cur == last) ? '0 : cur + port_id_t'(1);
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Bundle of requester-side and core-side signals of the arbiter. slave is the
// arbiter's view; master is the view of the requesters plus the SDRAM core.
interface sdram_port_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 8
);
    localparam int BE_W = DATA_W / 8;

    logic [NUM_PORTS*ADDR_W-1:0] port_addr_i;
    logic [NUM_PORTS*BE_W-1:0]   port_wr_i;
    logic [NUM_PORTS-1:0]        port_rd_i;
    logic [NUM_PORTS*LEN_W-1:0]  port_len_i;
    logic [NUM_PORTS*DATA_W-1:0] port_write_data_i;
    logic [NUM_PORTS-1:0]        port_accept_o;
    logic [NUM_PORTS-1:0]        port_ack_o;
    logic [NUM_PORTS-1:0]        port_error_o;
    logic [DATA_W-1:0]           port_read_data_o;

    logic [ADDR_W-1:0]           ram_addr_o;
    logic [BE_W-1:0]             ram_wr_o;
    logic                        ram_rd_o;
    logic [LEN_W-1:0]            ram_len_o;
    logic [DATA_W-1:0]           ram_write_data_o;
    logic                        ram_accept_i;
    logic                        ram_ack_i;
    logic                        ram_error_i;
    logic [DATA_W-1:0]           ram_read_data_i;
    logic                        unexpected_ack_o;

    modport slave (
        input  port_addr_i, port_wr_i, port_rd_i, port_len_i, port_write_data_i,
        output port_accept_o, port_ack_o, port_error_o, port_read_data_o,
        output ram_addr_o, ram_wr_o, ram_rd_o, ram_len_o, ram_write_data_o,
        input  ram_accept_i, ram_ack_i, ram_error_i, ram_read_data_i,
        output unexpected_ack_o
    );

    modport master (
        output port_addr_i, port_wr_i, port_rd_i, port_len_i, port_write_data_i,
        input  port_accept_o, port_ack_o, port_error_o, port_read_data_o,
        input  ram_addr_o, ram_wr_o, ram_rd_o, ram_len_o, ram_write_data_o,
        output ram_accept_i, ram_ack_i, ram_error_i, ram_read_data_i,
        input  unexpected_ack_o
    );

endinterface

// File: rtl/sdram_arb_resp_fifo.sv
// Response-order FIFO: one entry per in-flight transaction, with the head's
// remaining-response count decremented in place until its last ack pops it.
module sdram_arb_resp_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  resp_entry_t push_entry_i,
    input  logic        pop_i,
    input  logic        dec_i,
    output resp_entry_t head_o,
    output logic        full_o,
    output logic        empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    resp_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok, dec_ok;

    assign full_o  = (cnt_q == DEPTH_C);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign dec_ok  = dec_i & ~empty_o & ~pop_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop_ok)      cnt_d = cnt_q + (AW+1)'(1);
        else if (!push_ok && pop_ok) cnt_d = cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Push and decrement never target the same slot: push needs a free slot,
    // decrement needs a live head.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_entry_i;
        if (dec_ok)  mem_q[rd_ptr_q].count <= mem_q[rd_ptr_q].count - LEN_MAX_W'(1);
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM core RAM port among several requesters;
// write bursts keep the grant and responses are routed back in issue order.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int OUTSTANDING = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    sdram_port_arbiter_if.slave    bus
);
    localparam int       BE_W      = DATA_W / 8;
    localparam int       PW        = port_id_w(NUM_PORTS);
    localparam port_id_t LAST_PORT = port_id_t'(NUM_PORTS - 1);

    typedef logic [PW-1:0] pidx_t;

    logic [ADDR_W-1:0] addr_a  [NUM_PORTS];
    logic [BE_W-1:0]   wr_a    [NUM_PORTS];
    logic [LEN_W-1:0]  len_a   [NUM_PORTS];
    logic [DATA_W-1:0] wdata_a [NUM_PORTS];
    logic [NUM_PORTS-1:0] req;

    logic             lock_q, lock_d;
    pidx_t            lock_port_q, lock_port_d;
    logic [LEN_W-1:0] beats_q, beats_d;
    pidx_t            rr_q, rr_d;
    logic             unexp_q, unexp_d;

    pidx_t       grant, rr_adv;
    logic        found, fwd, beat, start, is_write;
    int          idx;
    logic        fifo_full, fifo_empty, fifo_pop, fifo_dec, resp_hit;
    resp_entry_t head, push_entry;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign addr_a[gi]  = bus.port_addr_i[gi*ADDR_W +: ADDR_W];
            assign wr_a[gi]    = bus.port_wr_i[gi*BE_W +: BE_W];
            assign len_a[gi]   = bus.port_len_i[gi*LEN_W +: LEN_W];
            assign wdata_a[gi] = bus.port_write_data_i[gi*DATA_W +: DATA_W];
            assign req[gi]     = bus.port_rd_i[gi] | (|wr_a[gi]);

            assign bus.port_accept_o[gi] = beat & (grant == PW'(gi));
            assign bus.port_ack_o[gi]    = resp_hit & (head.port == port_id_t'(gi));
            assign bus.port_error_o[gi]  = resp_hit & bus.ram_error_i & (head.port == port_id_t'(gi));
        end
    endgenerate

    always_comb begin
        grant = rr_q;
        found = 1'b0;
        idx   = 0;
        if (lock_q) begin
            grant = lock_port_q;
            found = req[lock_port_q];
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                idx = int'(rr_q) + i;
                if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
                if (!found && req[PW'(idx)]) begin
                    found = 1'b1;
                    grant = PW'(idx);
                end
            end
        end
    end

    // A new transaction needs a free FIFO slot; continuation beats were logged at start.
    assign fwd      = rst_ni & found & (lock_q | ~fifo_full);
    assign beat     = fwd & bus.ram_accept_i;
    assign start    = beat & ~lock_q;
    assign is_write = |wr_a[grant];
    assign rr_adv   = PW'(rr_next(port_id_t'(grant), LAST_PORT));

    assign bus.ram_addr_o       = addr_a[grant];
    assign bus.ram_len_o        = len_a[grant];
    assign bus.ram_write_data_o = wdata_a[grant];
    assign bus.ram_wr_o         = fwd ? wr_a[grant] : '0;
    assign bus.ram_rd_o         = fwd & bus.port_rd_i[grant];

    always_comb begin
        lock_d      = lock_q;
        lock_port_d = lock_port_q;
        beats_d     = beats_q;
        rr_d        = rr_q;
        if (start) begin
            if (is_write && (len_a[grant] != '0)) begin
                lock_d      = 1'b1;
                lock_port_d = grant;
                beats_d     = len_a[grant];
            end else begin
                rr_d = rr_adv;
            end
        end else if (beat) begin
            beats_d = beats_q - LEN_W'(1);
            if (beats_q == LEN_W'(1)) begin
                lock_d = 1'b0;
                rr_d   = rr_adv;
            end
        end
    end

    assign push_entry.port  = port_id_t'(grant);
    assign push_entry.count = LEN_MAX_W'(len_a[grant]);

    assign resp_hit = rst_ni & bus.ram_ack_i & ~fifo_empty;
    assign fifo_pop = resp_hit & (head.count == '0);
    assign fifo_dec = resp_hit & (head.count != '0);
    assign unexp_d  = unexp_q | (bus.ram_ack_i & fifo_empty);

    assign bus.port_read_data_o = bus.ram_read_data_i;
    assign bus.unexpected_ack_o = unexp_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q      <= 1'b0;
            lock_port_q <= '0;
            beats_q     <= '0;
            rr_q        <= '0;
            unexp_q     <= 1'b0;
        end else begin
            lock_q      <= lock_d;
            lock_port_q <= lock_port_d;
            beats_q     <= beats_d;
            rr_q        <= rr_d;
            unexp_q     <= unexp_d;
        end
    end

    sdram_arb_resp_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_resp_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (start),
        .push_entry_i (push_entry),
        .pop_i        (fifo_pop),
        .dec_i        (fifo_dec),
        .head_o       (head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a queue-based model checked every
// cycle on the falling edge, plus hand-computed literal expectations per scenario.
module tb_sdram_port_arbiter;
    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LW  = 8;
    localparam int OUT = 4;
    localparam int BW  = DW / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic          rd_v    [N];
    logic [BW-1:0] wr_v    [N];
    logic [LW-1:0] len_v   [N];
    logic [AW-1:0] addr_v  [N];
    logic [DW-1:0] wdata_v [N];
    logic          ram_accept, ram_ack, ram_error;
    logic [DW-1:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    // Model state: pointer, burst lock, and per-transaction acks still owed.
    int m_rr    = 0;
    bit m_lock  = 1'b0;
    int m_lport = 0;
    int m_left  = 0;
    bit m_unexp = 1'b0;
    int q_port [$];
    int q_acks [$];

    always #5 clk = ~clk;

    sdram_port_arbiter_if #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus_if ();

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_drv
            assign bus_if.port_rd_i[gi]                 = rd_v[gi];
            assign bus_if.port_wr_i[gi*BW +: BW]        = wr_v[gi];
            assign bus_if.port_len_i[gi*LW +: LW]       = len_v[gi];
            assign bus_if.port_addr_i[gi*AW +: AW]      = addr_v[gi];
            assign bus_if.port_write_data_i[gi*DW +: DW] = wdata_v[gi];
        end
    endgenerate

    assign bus_if.ram_accept_i    = ram_accept;
    assign bus_if.ram_ack_i       = ram_ack;
    assign bus_if.ram_error_i     = ram_error;
    assign bus_if.ram_read_data_i = ram_rdata;

    sdram_port_arbiter #(
        .NUM_PORTS   (N),
        .OUTSTANDING (OUT),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .LEN_W       (LW)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clr_all();
        for (int p = 0; p < N; p++) begin
            rd_v[p] = 1'b0; wr_v[p] = '0; len_v[p] = '0; addr_v[p] = '0; wdata_v[p] = '0;
        end
        ram_accept = 1'b0; ram_ack = 1'b0; ram_error = 1'b0; ram_rdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    always @(negedge clk) begin : cmp_proc
        logic [N-1:0] req;
        int  g, idx, exp_acc, exp_ack, exp_err;
        bit  found, fwd;
        if (!rst_n) begin
            chk("rst_accept", bus_if.port_accept_o, 0);
            chk("rst_ack", bus_if.port_ack_o, 0);
            chk("rst_ram_rd", bus_if.ram_rd_o, 0);
            chk("rst_ram_wr", bus_if.ram_wr_o, 0);
            m_rr = 0; m_lock = 1'b0; m_lport = 0; m_left = 0; m_unexp = 1'b0;
            q_port.delete(); q_acks.delete();
        end else begin
            for (int p = 0; p < N; p++) begin
                req[p] = rd_v[p] || (wr_v[p] != '0);
                if (rd_v[p] && (wr_v[p] != '0)) begin
                    errors++;
                    $display("FAIL illegal_stim port %0d rd and wr together", p);
                end
            end
            g = 0;
            found = 1'b0;
            if (m_lock) begin
                g = m_lport;
                found = req[g];
            end else begin
                for (int i = 0; i < N; i++) begin
                    idx = (m_rr + i) % N;
                    if (!found && req[idx]) begin
                        found = 1'b1;
                        g = idx;
                    end
                end
            end
            fwd = found && (m_lock || q_port.size() < OUT);
            exp_acc = (fwd && ram_accept) ? (1 << g) : 0;
            chk("accept", bus_if.port_accept_o, exp_acc);
            chk("ram_rd", bus_if.ram_rd_o, fwd && rd_v[g]);
            chk("ram_wr", bus_if.ram_wr_o, fwd ? wr_v[g] : '0);
            if (fwd) begin
                chk("ram_addr", bus_if.ram_addr_o, addr_v[g]);
                chk("ram_len", bus_if.ram_len_o, len_v[g]);
                if (wr_v[g] != '0) chk("ram_wdata", bus_if.ram_write_data_o, wdata_v[g]);
            end
            exp_ack = 0;
            exp_err = 0;
            if (ram_ack && q_port.size() > 0) begin
                exp_ack = 1 << q_port[0];
                exp_err = ram_error ? exp_ack : 0;
                chk("read_data", bus_if.port_read_data_o, ram_rdata);
                $display("ack port %0d data %08h error %0d", q_port[0], ram_rdata, ram_error);
            end
            chk("ack", bus_if.port_ack_o, exp_ack);
            chk("error", bus_if.port_error_o, exp_err);
            chk("unexpected_ack", bus_if.unexpected_ack_o, m_unexp);

            if (ram_ack) begin
                if (q_port.size() > 0) begin
                    q_acks[0] = q_acks[0] - 1;
                    if (q_acks[0] == 0) begin
                        void'(q_port.pop_front());
                        void'(q_acks.pop_front());
                    end
                end else begin
                    m_unexp = 1'b1;
                end
            end
            if (fwd && ram_accept) begin
                if (!m_lock) begin
                    q_port.push_back(g);
                    q_acks.push_back(int'(len_v[g]) + 1);
                    if ((wr_v[g] != '0) && (len_v[g] != '0)) begin
                        m_lock = 1'b1; m_lport = g; m_left = int'(len_v[g]);
                    end else begin
                        m_rr = (g + 1) % N;
                    end
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_lock = 1'b0;
                        m_rr = (g + 1) % N;
                    end
                end
            end
        end
    end

    initial begin
        int beats, cyc;
        clr_all();
        rst_n = 1'b0;

        // 1: reset holds everything quiet while every port requests
        for (int p = 0; p < N; p++) rd_v[p] = 1'b1;
        ram_accept = 1'b1; ram_ack = 1'b1;
        repeat (3) begin
            settle();
            chk("t1_accept", bus_if.port_accept_o, 0);
            chk("t1_ack", bus_if.port_ack_o, 0);
            chk("t1_ram_rd", bus_if.ram_rd_o, 0);
            step();
        end
        clr_all();
        rst_n = 1'b1;
        step();

        // 2: four single reads, grants 0..3, then acks in order
        for (int p = 0; p < N; p++) begin
            rd_v[p] = 1'b1; addr_v[p] = 32'h40 + 32'(p) * 32'h100;
        end
        ram_accept = 1'b1;
        for (int k = 0; k < N; k++) begin
            settle();
            chk("t2_grant", bus_if.port_accept_o, 1 << k);
            chk("t2_addr", bus_if.ram_addr_o, 32'h40 + 32'(k) * 32'h100);
            step();
            rd_v[k] = 1'b0;
        end
        ram_accept = 1'b0;
        for (int k = 0; k < N; k++) begin
            ram_ack = 1'b1; ram_rdata = 32'hA0 + 32'(k);
            settle();
            chk("t2_ack", bus_if.port_ack_o, 1 << k);
            chk("t2_data", bus_if.port_read_data_o, 32'hA0 + 32'(k));
            step();
        end
        ram_ack = 1'b0;

        // 3: port1 write burst of 4 with stalls holds off port2's read
        wr_v[1] = 4'hF; len_v[1] = 8'd3; addr_v[1] = 32'h1000; wdata_v[1] = 32'hD0;
        rd_v[2] = 1'b1; addr_v[2] = 32'h2000;
        beats = 0;
        cyc = 0;
        while (beats < 4 && cyc < 20) begin
            ram_accept = (cyc % 2 == 0);
            settle();
            chk("t3_burst_accept", bus_if.port_accept_o, ram_accept ? 4'b0010 : 4'b0000);
            chk("t3_burst_wr", bus_if.ram_wr_o, 4'hF);
            if (ram_accept) beats++;
            step();
            wdata_v[1] = 32'hD0 + 32'(beats);
            cyc++;
        end
        chk("t3_beats", beats, 4);
        wr_v[1] = '0;
        ram_accept = 1'b1;
        settle();
        chk("t3_port2_after", bus_if.port_accept_o, 4'b0100);
        step();
        rd_v[2] = 1'b0; ram_accept = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ram_ack = 1'b1; ram_rdata = 32'hC0 + 32'(k);
            settle();
            chk("t3_ack", bus_if.port_ack_o, (k < 4) ? 4'b0010 : 4'b0100);
            step();
        end
        ram_ack = 1'b0;

        // 4: outstanding limit blocks the fifth read until an ack pops
        rd_v[0] = 1'b1; addr_v[0] = 32'h500; ram_accept = 1'b1;
        for (int k = 0; k < OUT; k++) begin
            settle();
            chk("t4_fill", bus_if.port_accept_o, 4'b0001);
            step();
        end
        repeat (2) begin
            settle();
            chk("t4_full_rd", bus_if.ram_rd_o, 0);
            chk("t4_full_accept", bus_if.port_accept_o, 0);
            step();
        end
        ram_ack = 1'b1; ram_rdata = 32'h55;
        settle();
        chk("t4_pop_cycle_rd", bus_if.ram_rd_o, 0);
        chk("t4_pop_ack", bus_if.port_ack_o, 4'b0001);
        step();
        ram_ack = 1'b0;
        settle();
        chk("t4_after_pop_rd", bus_if.ram_rd_o, 1);
        chk("t4_after_pop_accept", bus_if.port_accept_o, 4'b0001);
        step();
        rd_v[0] = 1'b0; ram_accept = 1'b0;
        for (int k = 0; k < OUT; k++) begin
            ram_ack = 1'b1; ram_rdata = 32'h60 + 32'(k);
            step();
        end
        ram_ack = 1'b0;

        // 5: read burst of 8 on port3 with an error on the fifth ack
        rd_v[3] = 1'b1; len_v[3] = 8'd7; addr_v[3] = 32'h3000; ram_accept = 1'b1;
        settle();
        chk("t5_grant", bus_if.port_accept_o, 4'b1000);
        step();
        rd_v[3] = 1'b0; len_v[3] = '0; ram_accept = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ram_ack = 1'b1; ram_error = (k == 4); ram_rdata = 32'hB0 + 32'(k);
            settle();
            chk("t5_ack", bus_if.port_ack_o, 4'b1000);
            chk("t5_error", bus_if.port_error_o, (k == 4) ? 4'b1000 : 4'b0000);
            step();
        end
        ram_ack = 1'b0; ram_error = 1'b0;

        // 6: stray ack sets the sticky flag; reset mid-burst restarts at pointer 0
        ram_ack = 1'b1;
        settle();
        chk("t6_stray_ack", bus_if.port_ack_o, 0);
        step();
        ram_ack = 1'b0;
        settle();
        chk("t6_unexpected", bus_if.unexpected_ack_o, 1);
        repeat (3) step();
        settle();
        chk("t6_unexpected_sticky", bus_if.unexpected_ack_o, 1);
        step();
        rd_v[1] = 1'b1; ram_accept = 1'b1;
        step();
        rd_v[1] = 1'b0;
        wr_v[2] = 4'hF; len_v[2] = 8'd3; wdata_v[2] = 32'hE0;
        settle();
        chk("t6_burst_grant", bus_if.port_accept_o, 4'b0100);
        step();
        step();
        rst_n = 1'b0;
        clr_all();
        settle();
        chk("t6_rst_wr", bus_if.ram_wr_o, 0);
        chk("t6_rst_accept", bus_if.port_accept_o, 0);
        step();
        rst_n = 1'b1;
        rd_v[1] = 1'b1; rd_v[3] = 1'b1; ram_accept = 1'b1;
        settle();
        chk("t6_rr_after_reset", bus_if.port_accept_o, 4'b0010);
        chk("t6_unexpected_cleared", bus_if.unexpected_ack_o, 0);
        step();
        rd_v[1] = 1'b0;
        settle();
        chk("t6_next_grant", bus_if.port_accept_o, 4'b1000);
        step();
        clr_all();
        for (int k = 0; k < 2; k++) begin
            ram_ack = 1'b1; ram_rdata = 32'hF0 + 32'(k);
            settle();
            chk("t6_ack", bus_if.port_ack_o, (k == 0) ? 4'b0010 : 4'b1000);
            step();
        end
        ram_ack = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
